// File: rtl/if_stage.sv
// if_stage: instruction fetch with BOOT/RUN/HALT/FAULT control and IF/ID register; IF_ALIGN_CHECK_EN enables the misaligned-branch fault
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_Address,
  output logic        imem_ReadCtrl,
  input  logic [31:0] imem_Data,
  output logic [31:0] ifid_Instr,
  output logic [31:0] ifid_PCPlus4,
  output logic        ifid_Valid,
  output logic        halted,
  output logic        misalign_fault
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d, pc_inc;
  logic valid_q, valid_d, mis, br, redirect, adv, hold;
  assign pc_inc = pc_q + 32'd4;
  assign br = (state_q == RUN || state_q == HALT) && branch_taken;
  assign redirect = br && !mis;
  assign adv = state_q == RUN && !branch_taken && !stall;
  assign hold = state_q == RUN && !branch_taken && stall;
`ifdef IF_ALIGN_CHECK_EN
  logic fault_q;
  assign mis = branch_taken && |branch_target[1:0];
  assign misalign_fault = fault_q;
  always_ff @(posedge clk)
    fault_q <= rst ? 1'b0 : fault_q | (br && mis);
`else
  assign mis = 1'b0;
  assign misalign_fault = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= '0;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q == BOOT ? RUN :
              br ? (mis ? FAULT : RUN) :
              adv && imem_Data[31:26] == 6'h3f ? HALT : state_q;
  end
  always_comb begin
    pc_d    = redirect ? (branch_target & 32'hffff_fffc) : adv ? pc_inc : pc_q;
    instr_d = redirect ? '0 : adv ? imem_Data : instr_q;
    pcp4_d  = adv ? pc_inc : pcp4_q;
    valid_d = adv ? 1'b1 : hold ? valid_q : 1'b0;
  end
  always_comb begin
    imem_Address  = {24'b0, pc_q[9:2]};
    imem_ReadCtrl = state_q == RUN;
    halted        = state_q == HALT;
    ifid_Instr    = instr_q;
    ifid_PCPlus4  = pcp4_q;
    ifid_Valid    = valid_q;
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector self-checking bench for if_stage
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_Address, imem_Data, ifid_Instr, ifid_PCPlus4;
  logic        imem_ReadCtrl, ifid_Valid, halted, misalign_fault;
  logic [31:0] mem [256];
  int vectors = 0;
  int miscompares = 0;
  if_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_Address(imem_Address),
    .imem_ReadCtrl(imem_ReadCtrl),
    .imem_Data(imem_Data),
    .ifid_Instr(ifid_Instr),
    .ifid_PCPlus4(ifid_PCPlus4),
    .ifid_Valid(ifid_Valid),
    .halted(halted),
    .misalign_fault(misalign_fault)
  );
  always #5 clk = ~clk;
  assign imem_Data = mem[imem_Address[7:0]];
  function automatic logic [31:0] word(input int i);
    return 32'h0400_0000 | i;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_boot;
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    rst = 1'b1;
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    tick();
    vectors++;
    if (ifid_Valid !== 1'b0 || ifid_Instr !== 32'h0 || ifid_PCPlus4 !== 32'h0 || halted !== 1'b0 ||
        misalign_fault !== 1'b0 || imem_Address !== 32'h0 || imem_ReadCtrl !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: valid=%b instr=%h pcp4=%h halted=%b mis=%b addr=%h rd=%b, want all zero",
               ifid_Valid, ifid_Instr, ifid_PCPlus4, halted, misalign_fault, imem_Address, imem_ReadCtrl);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (ifid_Valid !== 1'b0 || imem_Address !== 32'h0 || imem_ReadCtrl !== 1'b1) begin
      miscompares++;
      $display("FAIL boot_ignores_inputs: valid=%b addr=%h rd=%b, want 0 0 1", ifid_Valid, imem_Address, imem_ReadCtrl);
    end
    stall = 1'b0;
    branch_taken = 1'b0;
  endtask
  task automatic test_fetch;
    reset_boot();
    vectors++;
    if (ifid_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_boot_valid: got %b want 0", ifid_Valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (ifid_Instr !== word(i) || ifid_PCPlus4 !== 32'(4 * (i + 1)) || ifid_Valid !== 1'b1) begin
        miscompares++;
        $display("FAIL fetch_%0d: instr=%h pcp4=%h valid=%b, want %h %h 1",
                 i, ifid_Instr, ifid_PCPlus4, ifid_Valid, word(i), 32'(4 * (i + 1)));
      end
    end
  endtask
  task automatic test_stall;
    reset_boot();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (ifid_Instr !== word(1) || ifid_PCPlus4 !== 32'd8 || ifid_Valid !== 1'b1 || imem_Address !== 32'd2) begin
        miscompares++;
        $display("FAIL stall_%0d: instr=%h pcp4=%h valid=%b addr=%h, want %h 8 1 2",
                 i, ifid_Instr, ifid_PCPlus4, ifid_Valid, imem_Address, word(1));
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (ifid_Instr !== word(2) || ifid_PCPlus4 !== 32'd12 || ifid_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_resume: instr=%h pcp4=%h valid=%b, want %h c 1", ifid_Instr, ifid_PCPlus4, ifid_Valid, word(2));
    end
  endtask
  task automatic test_branch_stall;
    reset_boot();
    tick();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick();
    vectors++;
    if (ifid_Valid !== 1'b0 || ifid_Instr !== 32'h0 || imem_Address !== 32'd16) begin
      miscompares++;
      $display("FAIL branch_redirect: valid=%b instr=%h addr=%h, want 0 0 10", ifid_Valid, ifid_Instr, imem_Address);
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    tick();
    vectors++;
    if (ifid_Instr !== word(16) || ifid_PCPlus4 !== 32'h44 || ifid_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_fetch: instr=%h pcp4=%h valid=%b, want %h 44 1", ifid_Instr, ifid_PCPlus4, ifid_Valid, word(16));
    end
  endtask
  task automatic test_halt;
    mem[5] = 32'hFC00_0000;
    reset_boot();
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (ifid_Instr !== 32'hFC00_0000 || ifid_Valid !== 1'b1 || halted !== 1'b1 || ifid_PCPlus4 !== 32'd24 || imem_Address !== 32'd6) begin
      miscompares++;
      $display("FAIL halt_enter: instr=%h valid=%b halted=%b pcp4=%h addr=%h, want fc000000 1 1 18 6",
               ifid_Instr, ifid_Valid, halted, ifid_PCPlus4, imem_Address);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (ifid_Valid !== 1'b0 || halted !== 1'b1 || imem_Address !== 32'd6 || imem_ReadCtrl !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_hold_%0d: valid=%b halted=%b addr=%h rd=%b, want 0 1 6 0", i, ifid_Valid, halted, imem_Address, imem_ReadCtrl);
      end
    end
    branch_taken = 1'b1;
    branch_target = 32'h0;
    tick();
    branch_taken = 1'b0;
    vectors++;
    if (halted !== 1'b0 || ifid_Valid !== 1'b0 || imem_Address !== 32'd0) begin
      miscompares++;
      $display("FAIL halt_exit: halted=%b valid=%b addr=%h, want 0 0 0", halted, ifid_Valid, imem_Address);
    end
    tick();
    vectors++;
    if (ifid_Instr !== word(0) || ifid_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_refetch: instr=%h valid=%b, want %h 1", ifid_Instr, ifid_Valid, word(0));
    end
    mem[5] = word(5);
  endtask
  task automatic test_wrap;
    reset_boot();
    branch_taken = 1'b1;
    branch_target = 32'h3FC;
    tick();
    branch_taken = 1'b0;
    vectors++;
    if (imem_Address !== 32'd255) begin
      miscompares++;
      $display("FAIL wrap_addr255: got %h want ff", imem_Address);
    end
    tick();
    vectors++;
    if (imem_Address !== 32'd0 || ifid_Instr !== word(255) || ifid_PCPlus4 !== 32'h400) begin
      miscompares++;
      $display("FAIL wrap_addr0: addr=%h instr=%h pcp4=%h, want 0 %h 400", imem_Address, ifid_Instr, ifid_PCPlus4, word(255));
    end
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    vectors++;
    if (ifid_PCPlus4 !== 32'h0 || imem_Address !== 32'd0 || ifid_Instr !== word(255)) begin
      miscompares++;
      $display("FAIL wrap_2_32: pcp4=%h addr=%h instr=%h, want 0 0 %h", ifid_PCPlus4, imem_Address, ifid_Instr, word(255));
    end
  endtask
  task automatic test_misalign;
    reset_boot();
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h42;
    tick();
    branch_taken = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (misalign_fault !== 1'b1 || imem_Address !== 32'd1 || ifid_Valid !== 1'b0 || imem_ReadCtrl !== 1'b0) begin
        miscompares++;
        $display("FAIL misalign_fault_%0d: mis=%b addr=%h valid=%b rd=%b, want 1 1 0 0",
                 i, misalign_fault, imem_Address, ifid_Valid, imem_ReadCtrl);
      end
      branch_taken = 1'b1;
      branch_target = 32'h40;
      tick();
      branch_taken = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (misalign_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_reset: mis=%b want 0", misalign_fault);
    end
`else
    vectors++;
    if (misalign_fault !== 1'b0 || imem_Address !== 32'd16 || ifid_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_redirect: mis=%b addr=%h valid=%b, want 0 10 0", misalign_fault, imem_Address, ifid_Valid);
    end
    tick();
    vectors++;
    if (ifid_Instr !== word(16) || ifid_PCPlus4 !== 32'h44 || ifid_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_fetch: instr=%h pcp4=%h valid=%b, want %h 44 1", ifid_Instr, ifid_PCPlus4, ifid_Valid, word(16));
    end
`endif
  endtask
  task automatic test_reset_mid_stall;
    reset_boot();
    tick();
    tick();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    vectors++;
    if (ifid_Valid !== 1'b0 || ifid_Instr !== 32'h0 || ifid_PCPlus4 !== 32'h0 || imem_Address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: valid=%b instr=%h pcp4=%h addr=%h, want all zero", ifid_Valid, ifid_Instr, ifid_PCPlus4, imem_Address);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word(i);
    test_reset();
    test_fetch();
    test_stall();
    test_branch_stall();
    test_halt();
    test_wrap();
    test_misalign();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
